ii_window_buf: RTL and testbench

//  Captures one FEATURE_WIDTH x FEATURE_HEIGHT integral-image window from the ii_gen output stream into on-chip RAM.

---
 rtl/ii_window_buf_if.sv | 30 +++
 rtl/ii_window_buf.sv | 117 +++++++++++
 tb/tb_ii_window_buf.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ii_window_buf_if.sv
// Stream-in, window-status and random-read signals of the integral-image window buffer.
// The producer/evaluator side uses master; the buffer uses slave.
interface ii_window_buf_if #(
  parameter int W_DATA_ACCUM = 26,
  parameter int W_X          = 5,
  parameter int W_Y          = 5
);
  logic                    din_valid;
  logic                    din_ready;
  logic [W_DATA_ACCUM-1:0] din_data;
  logic [1:0]              din_eot;
  logic                    win_valid;
  logic                    win_release;
  logic                    rd_en;
  logic [W_X-1:0]          rd_x;
  logic [W_Y-1:0]          rd_y;
  logic                    rd_valid;
  logic [W_DATA_ACCUM-1:0] rd_data;
  logic                    eot_err;

  modport master (
    output din_valid, din_data, din_eot, win_release, rd_en, rd_x, rd_y,
    input  din_ready, win_valid, rd_valid, rd_data, eot_err
  );

  modport slave (
    input  din_valid, din_data, din_eot, win_release, rd_en, rd_x, rd_y,
    output din_ready, win_valid, rd_valid, rd_data, eot_err
  );
endinterface

// File: rtl/ii_window_buf.sv
// Single-buffer integral-image window store: fills one window at 1 word/cycle, then serves 1-cycle random reads.
// Stream is stalled (din_ready=0) from window completion until the consumer releases the window.
module ii_window_buf #(
  parameter int W_DATA_ACCUM   = 26,
  parameter int FEATURE_WIDTH  = 24,
  parameter int FEATURE_HEIGHT = 24
) (
  input logic            clk,
  input logic            rst,
  ii_window_buf_if.slave bus
);
  localparam int W_X   = $clog2(FEATURE_WIDTH);
  localparam int W_Y   = $clog2(FEATURE_HEIGHT);
  localparam int DEPTH = FEATURE_WIDTH * FEATURE_HEIGHT;
  localparam int W_A   = $clog2(DEPTH);

  typedef enum logic {FILL, READY} state_t;

  state_t                  state_q, state_d;
  logic [W_X-1:0]          col_q, col_d;
  logic [W_Y-1:0]          row_q, row_d;
  logic                    eot_err_q;
  logic                    rd_valid_q;
  logic [W_DATA_ACCUM-1:0] rd_data_q;

  logic [W_DATA_ACCUM-1:0] mem [DEPTH];

  logic           accept;
  logic           col_last;
  logic           row_last;
  logic           pos_last;
  logic           last_word;
  logic           eot_bad;
  logic           rd_fire;
  logic           rd_in_range;
  logic [W_A-1:0] wr_addr;
  logic [W_A-1:0] rd_addr;

  assign accept    = bus.din_valid && (state_q == FILL);
  assign col_last  = (col_q == W_X'(FEATURE_WIDTH - 1));
  assign row_last  = (row_q == W_Y'(FEATURE_HEIGHT - 1));
  assign pos_last  = col_last && row_last;
  // An early end-of-window marker still closes the window; the positional check flags it.
  assign last_word = pos_last || bus.din_eot[1];
  assign eot_bad   = (bus.din_eot[0] != col_last) || (bus.din_eot[1] != pos_last);

  assign wr_addr = W_A'(row_q) * W_A'(FEATURE_WIDTH) + W_A'(col_q);
  assign rd_addr = W_A'(bus.rd_y) * W_A'(FEATURE_WIDTH) + W_A'(bus.rd_x);

  // Comparisons are one bit wider so power-of-two window sizes don't truncate the bound.
  assign rd_in_range = ({1'b0, bus.rd_x} < (W_X + 1)'(FEATURE_WIDTH)) &&
                       ({1'b0, bus.rd_y} < (W_Y + 1)'(FEATURE_HEIGHT));
  assign rd_fire     = bus.rd_en && (state_q == READY);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (last_word) begin
            state_d = READY;
            col_d   = '0;
            row_d   = '0;
          end else if (col_last) begin
            col_d = '0;
            row_d = row_q + W_Y'(1);
          end else begin
            col_d = col_q + W_X'(1);
          end
        end
      end
      READY: begin
        if (bus.win_release) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      col_q      <= '0;
      row_q      <= '0;
      eot_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rd_valid_q <= rd_fire;
      if (accept && eot_bad) begin
        eot_err_q <= 1'b1;
      end
      if (rd_fire) begin
        rd_data_q <= rd_in_range ? mem[rd_addr] : '0;
      end
    end
  end

  // Storage kept reset-free so it maps onto a block RAM write port.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr] <= bus.din_data;
    end
  end

  assign bus.din_ready = (state_q == FILL);
  assign bus.win_valid = (state_q == READY);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.eot_err   = eot_err_q;
endmodule

// File: tb/tb_ii_window_buf.sv
// Directed bench for ii_window_buf: fill, gapped fill, stall/release, eot errors, early window end, mid-fill reset.
module tb_ii_window_buf;
  localparam int WD = 26;
  localparam int WX = 5;
  localparam int WY = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ii_window_buf_if #(.W_DATA_ACCUM(WD), .W_X(WX), .W_Y(WY)) bus ();

  ii_window_buf #(
    .W_DATA_ACCUM  (WD),
    .FEATURE_WIDTH (24),
    .FEATURE_HEIGHT(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic idle_inputs();
    bus.din_valid   = 1'b0;
    bus.din_data    = '0;
    bus.din_eot     = 2'b00;
    bus.win_release = 1'b0;
    bus.rd_en       = 1'b0;
    bus.rd_x        = '0;
    bus.rd_y        = '0;
  endtask

  // Streams words base+i for i=0..n-1; bad_idx forces eot[0], early_idx forces eot=2'b11.
  task automatic stream(input int base, input int n, input bit gap,
                        input int bad_idx, input int early_idx, input string tag);
    int ready_low = 0;
    int vld_early = 0;
    for (int i = 0; i < n; i++) begin
      if (gap && ($urandom_range(1) == 1)) begin
        bus.din_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.din_valid = 1'b1;
      bus.din_data  = WD'(base + i);
      bus.din_eot   = {(i == 575) || (i == early_idx),
                       ((i % 24) == 23) || (i == bad_idx) || (i == early_idx)};
      if (bus.din_ready !== 1'b1) ready_low++;
      if (bus.win_valid !== 1'b0) vld_early++;
      @(posedge clk); #1;
    end
    bus.din_valid = 1'b0;
    bus.din_eot   = 2'b00;
    n_cmp++;
    if (ready_low != 0 || vld_early != 0) begin
      n_bad++;
      $display("FAIL %s fill_handshake: ready_low_cycles=%0d win_valid_early=%0d required 0/0",
               tag, ready_low, vld_early);
    end
  endtask

  task automatic check_window_done(input string tag);
    n_cmp++;
    if (bus.win_valid !== 1'b1 || bus.din_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s window_done: win_valid=%b din_ready=%b required 1/0",
               tag, bus.win_valid, bus.din_ready);
    end
  endtask

  task automatic rd(input int x, input int y, input int exp, input string tag);
    bus.rd_en = 1'b1;
    bus.rd_x  = x[WX-1:0];
    bus.rd_y  = y[WY-1:0];
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== WD'(exp)) begin
      n_bad++;
      $display("FAIL %s read(%0d,%0d): rd_valid=%b rd_data=%0d required 1/%0d",
               tag, x, y, bus.rd_valid, bus.rd_data, exp);
    end
  endtask

  task automatic check_eot_err(input logic exp, input string tag);
    n_cmp++;
    if (bus.eot_err !== exp) begin
      n_bad++;
      $display("FAIL %s eot_err: got %b required %b", tag, bus.eot_err, exp);
    end
  endtask

  task automatic release_window();
    bus.win_release = 1'b1;
    @(posedge clk); #1;
    bus.win_release = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.din_ready !== 1'b1 || bus.win_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset ready/valid: din_ready=%b win_valid=%b required 1/0", bus.din_ready, bus.win_valid);
    end
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
      n_bad++;
      $display("FAIL reset read_port: rd_valid=%b rd_data=%0d required 0/0", bus.rd_valid, bus.rd_data);
    end
    check_eot_err(1'b0, "reset");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_window();
    stream(0, 576, 1'b0, -1, -1, "full");
    check_window_done("full");
    rd(5, 3, 77, "full");
    rd(23, 23, 575, "full");
    @(posedge clk); #1;
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== WD'(575)) begin
      n_bad++;
      $display("FAIL full read_idle_hold: rd_valid=%b rd_data=%0d required 0/575", bus.rd_valid, bus.rd_data);
    end
    check_eot_err(1'b0, "full");
    release_window();
  endtask

  task automatic test_gapped_fill();
    stream(0, 576, 1'b1, -1, -1, "gapped");
    check_window_done("gapped");
  endtask

  task automatic test_back_to_back();
    rd(0, 0, 0, "b2b");
    rd(5, 3, 77, "b2b");
    rd(22, 10, 262, "b2b");
    rd(1, 0, 1, "b2b");
  endtask

  task automatic test_stall_release();
    int taken = 0;
    bus.din_valid = 1'b1;
    bus.din_data  = WD'(999);
    for (int i = 0; i < 3; i++) begin
      if (bus.din_ready !== 1'b0) taken++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (taken != 0) begin
      n_bad++;
      $display("FAIL stall din_ready: high for %0d cycles in READY required 0", taken);
    end
    rd(1, 0, 1, "stall");
    bus.win_release = 1'b1;
    bus.rd_en       = 1'b1;
    bus.rd_x        = '0;
    bus.rd_y        = '0;
    @(posedge clk); #1;
    bus.win_release = 1'b0;
    bus.rd_en       = 1'b0;
    bus.din_valid   = 1'b0;
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== WD'(0) || bus.win_valid !== 1'b0 || bus.din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release_read: rd_valid=%b rd_data=%0d win_valid=%b din_ready=%b required 1/0/0/1",
               bus.rd_valid, bus.rd_data, bus.win_valid, bus.din_ready);
    end
    bus.rd_en = 1'b1;
    bus.rd_x  = 5'd5;
    bus.rd_y  = 5'd3;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== WD'(0)) begin
      n_bad++;
      $display("FAIL fill_read_ignored: rd_valid=%b rd_data=%0d required 0/0", bus.rd_valid, bus.rd_data);
    end
    stream(1000, 576, 1'b0, -1, -1, "refill");
    check_window_done("refill");
    rd(0, 0, 1000, "refill");
    rd(23, 23, 1575, "refill");
    release_window();
  endtask

  task automatic test_eot_error();
    check_eot_err(1'b0, "eot_pre");
    stream(2000, 576, 1'b0, 10, -1, "eot_bad");
    check_window_done("eot_bad");
    check_eot_err(1'b1, "eot_bad");
    rd(10, 0, 2010, "eot_bad");
    rd(11, 0, 2011, "eot_bad");
    rd(0, 1, 2024, "eot_bad");
    release_window();
  endtask

  task automatic test_early_end();
    stream(0, 101, 1'b0, -1, 100, "early");
    check_window_done("early");
    check_eot_err(1'b1, "early_sticky");
    rd(4, 4, 100, "early");
    rd(4, 3, 76, "early");
    rd(5, 5, 2125, "early_stale");
    rd(25, 0, 0, "early_oor_x");
    rd(0, 24, 0, "early_oor_y");
    release_window();
  endtask

  task automatic test_reset_mid_fill();
    stream(500, 300, 1'b0, -1, -1, "partial");
    bus.din_valid = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.din_ready !== 1'b1 || bus.win_valid !== 1'b0 || bus.rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset outputs: din_ready=%b win_valid=%b rd_valid=%b required 1/0/0",
               bus.din_ready, bus.win_valid, bus.rd_valid);
    end
    check_eot_err(1'b0, "midreset");
    bus.din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    stream(3000, 576, 1'b0, -1, -1, "fresh");
    check_window_done("fresh");
    rd(0, 0, 3000, "fresh");
    rd(7, 12, 3295, "fresh");
    rd(23, 23, 3575, "fresh");
    check_eot_err(1'b0, "fresh");
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_gapped_fill();
    test_back_to_back();
    test_stall_release();
    test_eot_error();
    test_early_end();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
